multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
- Multicycle sequencer FSM that drives the 3-bit-opcode datapath (add, sub, load, save) one instruction at a time.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memory.
- Counts retired instructions and flags memory timeouts.
- Sits between the instruction register / memories and the ALU, register file and PC.

Parameters:
- TIMEOUT, 16: max cycles spent in MEM waiting for dmem_ack before entering ERROR (>=1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching (sampled in IDLE only).
- halt_req  in  1  return to IDLE after the current instruction (sampled in WB).
- opcode  in  3  instruction opcode: 100 add, 110 sub, 001 load, 010 save.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  advance PC.
- mem_read  out  1  data memory read.
- mem_write  out  1  data memory write.
- mem_to_reg  out  1  writeback source is memory.
- alu_op  out  1  0 add, 1 sub.
- alu_src  out  1  ALU operand B is immediate.
- reg_write  out  1  register file write enable.
- busy  out  1  state is not IDLE and not ERROR.
- err  out  1  sticky error flag.
- state_o  out  3  current state encoding.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset: state=IDLE, op_q=000, timeout counter=0, retired=0, err=0. All control outputs 0.
- Reset asserted mid-instruction aborts immediately; no partial writes after rst_n falls.
- State encoding: IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, ERROR=111.
- IDLE -> FETCH when start=1; start is ignored in every other state.
- FETCH: imem_req=1 while waiting.
  - ir_write = FETCH & imem_ack (same cycle, Mealy).
  - On imem_ack -> DECODE; otherwise stay in FETCH.
- DECODE: op_q <= opcode.
  - Legal opcode -> EXEC.
  - Illegal opcode: see Optional Feature.
- EXEC (1 cycle): alu_op = (op_q==110); alu_src = op_q is load or save.
  - add/sub -> WB; load/save -> MEM.
- MEM: mem_read=1 for load, mem_write=1 for save, held steadily until dmem_ack.
  - alu_src=1 throughout.
  - Timeout counter clears on MEM entry and increments each MEM cycle without ack.
  - dmem_ack -> WB (ack on the TIMEOUT-th cycle still wins).
  - Counter reaching TIMEOUT without ack -> ERROR.
- WB (1 cycle): pc_write=1.
  - reg_write=1 for add, sub and load; 0 for save and NOP.
  - mem_to_reg=1 for load.
  - retired increments, wrapping from all-ones to 0.
  - halt_req=1 -> IDLE, otherwise -> FETCH.
- ERROR: err=1 and all other control outputs 0; busy=0. Exit only via rst_n.
- Latency with zero-wait memories:
  - add/sub: 4 cycles from FETCH entry to next FETCH.
  - load/save: 5 cycles.
- Control outputs other than ir_write are Moore, decoded from state and op_q.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE -> ERROR with err=1. retired does not increment; pc_write is not asserted.
- Undefined: an illegal opcode is a NOP: DECODE -> WB with reg_write=0 and pc_write=1. retired increments.

Test Plan:
- Reset, start=1, imem_ack always 1, opcode=100 -> FETCH, DECODE, EXEC, WB in 4 cycles; reg_write=1 and alu_op=0 in WB; retired=1.
- opcode=110 with imem_ack delayed 3 cycles -> imem_req high for 4 FETCH cycles; ir_write pulses once; alu_op=1 in EXEC; retired=1.
- opcode=001, dmem_ack after 2 MEM cycles -> mem_read high exactly 3 cycles; WB shows mem_to_reg=1 and reg_write=1.
- opcode=010, TIMEOUT=4, dmem_ack never -> ERROR after 4 MEM cycles; err=1, state_o=111; mem_write drops; busy=0.
- Illegal opcode 111 -> with ILLEGAL_TRAP_EN: err=1 and retired unchanged; without: NOP WB, pc_write=1, retired+1.
- halt_req=1 during WB of the 3rd instruction -> IDLE with retired=3; rst_n pulled low mid-MEM -> outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/multicycle_seq.sv
// multicycle_seq: multicycle sequencer FSM (fetch/decode/exec/mem/wb) for a 3-bit-opcode datapath
//   in : clk, rst_n (async active-low), start, halt_req, opcode[2:0], imem_ack, dmem_ack
//   out: imem_req, ir_write, pc_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src,
//        reg_write, busy, err, state_o[2:0], retired[CNT_W-1:0]
//   ILLEGAL_TRAP_EN: when defined an illegal opcode traps to ERROR, otherwise it retires as a NOP
module multicycle_seq #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic [2:0]       opcode,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             alu_op,
   output logic             alu_src,
   output logic             reg_write,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired
);
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      FETCH  = 3'b001,
      DECODE = 3'b010,
      EXEC   = 3'b011,
      MEM    = 3'b100,
      WB     = 3'b101,
      ERROR  = 3'b111
   } state_t;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_ST  = 3'b010;
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic imem_req_q, imem_req_d, pc_write_q, pc_write_d, mem_read_q, mem_read_d;
   logic mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d, alu_op_q, alu_op_d;
   logic alu_src_q, alu_src_d, reg_write_q, reg_write_d, busy_q, busy_d, err_q, err_d;
   logic legal, is_mem_op;
   always_comb begin
      legal     = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LD) || (opcode == OP_ST);
      state_d   = state_q;
      op_d      = op_q;
      tmo_d     = tmo_q;
      retired_d = retired_q;
      case (state_q)
         IDLE:   state_d = start ? FETCH : IDLE;
         FETCH:  state_d = imem_ack ? DECODE : FETCH;
         DECODE: begin
            op_d = opcode;
`ifdef ILLEGAL_TRAP_EN
            state_d = legal ? EXEC : ERROR;
`else
            state_d = legal ? EXEC : WB;
`endif
         end
         EXEC: begin
            tmo_d   = '0;
            state_d = (op_q == OP_LD || op_q == OP_ST) ? MEM : WB;
         end
         // ack on the final allowed cycle still completes the access
         MEM: begin
            if (dmem_ack) state_d = WB;
            else if (tmo_q == TW'(TIMEOUT - 1)) state_d = ERROR;
            else tmo_d = tmo_q + 1'b1;
         end
         WB: begin
            retired_d = retired_q + 1'b1;
            state_d   = halt_req ? IDLE : FETCH;
         end
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
      // outputs are registered, so decode them from the next state to keep them aligned with state_q
      is_mem_op    = (op_d == OP_LD) || (op_d == OP_ST);
      imem_req_d   = state_d == FETCH;
      pc_write_d   = state_d == WB;
      mem_read_d   = (state_d == MEM) && (op_d == OP_LD);
      mem_write_d  = (state_d == MEM) && (op_d == OP_ST);
      mem_to_reg_d = (state_d == WB) && (op_d == OP_LD);
      alu_op_d     = (state_d == EXEC) && (op_d == OP_SUB);
      alu_src_d    = (state_d == EXEC || state_d == MEM) && is_mem_op;
      reg_write_d  = (state_d == WB) && (op_d == OP_ADD || op_d == OP_SUB || op_d == OP_LD);
      busy_d       = (state_d != IDLE) && (state_d != ERROR);
      err_d        = state_d == ERROR;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         tmo_q        <= '0;
         retired_q    <= '0;
         imem_req_q   <= 1'b0;
         pc_write_q   <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_op_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         tmo_q        <= tmo_d;
         retired_q    <= retired_d;
         imem_req_q   <= imem_req_d;
         pc_write_q   <= pc_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_op_q     <= alu_op_d;
         alu_src_q    <= alu_src_d;
         reg_write_q  <= reg_write_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end
   assign ir_write   = (state_q == FETCH) && imem_ack;
   assign imem_req   = imem_req_q;
   assign pc_write   = pc_write_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_to_reg = mem_to_reg_q;
   assign alu_op     = alu_op_q;
   assign alu_src    = alu_src_q;
   assign reg_write  = reg_write_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign state_o    = state_q;
   assign retired    = retired_q;
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: scoreboard bench for multicycle_seq (WB/ERROR events checked by a monitor)
module tb_multicycle_seq;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic halt_req, imem_ack, dmem_ack;
   logic [2:0] opcode = 3'b000;
   logic imem_req, ir_write, pc_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write, busy, err;
   logic [2:0] state_o;
   logic [15:0] retired;
   typedef struct packed {
      logic [2:0]  st;
      logic        pc, rw, m2r, aop, er;
      logic [15:0] ret;
   } rec_t;
   rec_t exp_q[$];
   int total = 0, bad = 0;
   int imem_dly = 0, dmem_dly = 0, halt_at = 1;
   int fcnt = 0, mcnt = 0, wb_seen = 0;
   int n_busy, n_imem, n_ir, n_pc, n_rd, n_wr, n_aop, n_src;
   always #5 clk = ~clk;
   multicycle_seq #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .opcode(opcode),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_write(ir_write),
      .pc_write(pc_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .busy(busy), .err(err),
      .state_o(state_o), .retired(retired)
   );
   // memory responders: ack after a programmable number of wait cycles
   always @(negedge clk) begin
      fcnt    <= (state_o == 3'd1) ? fcnt + 1 : 0;
      mcnt    <= (state_o == 3'd4) ? mcnt + 1 : 0;
      wb_seen <= wb_seen + int'(pc_write);
   end
   assign imem_ack = (state_o == 3'd1) && (fcnt > imem_dly);
   assign dmem_ack = (state_o == 3'd4) && (mcnt > dmem_dly);
   assign halt_req = pc_write && (wb_seen >= halt_at);
   function automatic rec_t mk(input int st, pc, rw, m2r, aop, er, ret);
      return '{st: 3'(st), pc: 1'(pc), rw: 1'(rw), m2r: 1'(m2r), aop: 1'(aop), er: 1'(er), ret: 16'(ret)};
   endfunction
   task automatic chk(input string nm, input int act, input int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, expv);
      end
   endtask
   task automatic monitor();
      logic err_prev = 1'b0;
      rec_t a, e;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) err_prev = 1'b0;
         else begin
            if (pc_write || (err && !err_prev)) begin
               a = '{st: state_o, pc: pc_write, rw: reg_write, m2r: mem_to_reg, aop: alu_op, er: err, ret: retired};
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL sb_unexpected: got %h want none", a);
               end else begin
                  e = exp_q.pop_front();
                  if (a !== e) begin
                     bad++;
                     $display("FAIL sb_event: got %h want %h", a, e);
                  end
               end
            end
            err_prev = err;
         end
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask
   task automatic go(input logic [2:0] op, input int idly, input int ddly, input int nh);
      bit done = 0;
      opcode = op; imem_dly = idly; dmem_dly = ddly; halt_at = wb_seen + nh;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n_busy = 0; n_imem = 0; n_ir = 0; n_pc = 0; n_rd = 0; n_wr = 0; n_aop = 0; n_src = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk); #1;
         if (state_o == 3'd0 || state_o == 3'd7) done = 1;
         else begin
            n_busy += int'(busy); n_imem += int'(imem_req); n_ir += int'(ir_write); n_pc += int'(pc_write);
            n_rd += int'(mem_read); n_wr += int'(mem_write); n_aop += int'(alu_op); n_src += int'(alu_src);
            if (mem_read && mem_write) chk("rd_wr_exclusive", 1, 0);
         end
      end
      chk("run_terminated", int'(done), 1);
   endtask
   initial begin
      fork monitor(); join_none
      repeat (2) @(negedge clk); #1;
      chk("rst_state", state_o, 0);
      chk("rst_ctrl", int'({imem_req, ir_write, pc_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write, busy, err}), 0);
      chk("rst_retired", retired, 0);
      rst_n = 1'b1;
      // add, zero-wait
      exp_q.push_back(mk(5, 1, 1, 0, 0, 0, 0));
      go(3'b100, 0, 0, 1);
      chk("add_busy", n_busy, 4); chk("add_ir", n_ir, 1); chk("add_retired", retired, 1);
      // sub with 3-cycle instruction wait
      do_reset();
      exp_q.push_back(mk(5, 1, 1, 0, 0, 0, 0));
      go(3'b110, 3, 0, 1);
      chk("sub_busy", n_busy, 7); chk("sub_imem_req", n_imem, 4); chk("sub_ir", n_ir, 1);
      chk("sub_alu_op", n_aop, 1); chk("sub_retired", retired, 1);
      // load with 2 data wait cycles, then zero-wait save
      do_reset();
      exp_q.push_back(mk(5, 1, 1, 1, 0, 0, 0));
      go(3'b001, 0, 2, 1);
      chk("ld_busy", n_busy, 7); chk("ld_mem_read", n_rd, 3); chk("ld_mem_write", n_wr, 0);
      chk("ld_alu_src", n_src, 4); chk("ld_retired", retired, 1);
      exp_q.push_back(mk(5, 1, 0, 0, 0, 0, 1));
      go(3'b010, 0, 0, 1);
      chk("st_busy", n_busy, 5); chk("st_mem_write", n_wr, 1); chk("st_mem_read", n_rd, 0);
      chk("st_retired", retired, 2);
      // save timeout -> ERROR
      do_reset();
      exp_q.push_back(mk(7, 0, 0, 0, 0, 1, 0));
      go(3'b010, 0, 255, 1);
      chk("to_busy", n_busy, 7); chk("to_mem_write", n_wr, 4);
      chk("to_state", state_o, 7); chk("to_err", err, 1); chk("to_busy_out", busy, 0); chk("to_mem_write_drop", mem_write, 0);
      repeat (3) @(negedge clk); #1;
      chk("to_err_sticky", err, 1); chk("to_state_sticky", state_o, 7);
      // illegal opcode
      do_reset();
`ifdef ILLEGAL_TRAP_EN
      exp_q.push_back(mk(7, 0, 0, 0, 0, 1, 0));
      go(3'b111, 0, 0, 1);
      chk("ill_busy", n_busy, 2); chk("ill_pc", n_pc, 0); chk("ill_err", err, 1); chk("ill_retired", retired, 0);
`else
      exp_q.push_back(mk(5, 1, 0, 0, 0, 0, 0));
      go(3'b111, 0, 0, 1);
      chk("ill_busy", n_busy, 3); chk("ill_pc", n_pc, 1); chk("ill_err", err, 0); chk("ill_retired", retired, 1);
`endif
      // three adds, halt during the third WB
      do_reset();
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(5, 1, 1, 0, 0, 0, k));
      go(3'b100, 0, 0, 3);
      chk("halt_busy", n_busy, 12); chk("halt_state", state_o, 0); chk("halt_retired", retired, 3);
      // reset mid-MEM aborts immediately
      opcode = 3'b001; dmem_dly = 255;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 20 && state_o != 3'd4; i++) begin @(negedge clk); #1; end
      chk("abort_in_mem", state_o, 4);
      @(negedge clk); #1;
      chk("abort_mem_read", mem_read, 1);
      rst_n = 1'b0; #1;
      chk("abort_state", state_o, 0);
      chk("abort_ctrl", int'({imem_req, ir_write, pc_write, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write, busy, err}), 0);
      chk("abort_retired", retired, 0);
      repeat (2) @(negedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk); #1;
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
